// File: rtl/hd44780_nibble_writer_if.sv
// hd44780_nibble_writer_if: byte handshake between the LCD controller and the nibble writer.
interface hd44780_nibble_writer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_rs;
    logic       in_ready;
    logic       done;
    modport master (output in_valid, in_data, in_rs, input in_ready, done);
    modport slave  (input in_valid, in_data, in_rs, output in_ready, done);
endinterface

// File: rtl/hd44780_nibble_writer.sv
// hd44780_nibble_writer: writes one byte to an HD44780 as two tick-paced 4-bit transfers.
module hd44780_nibble_writer #(
    parameter int SETUP_TICKS     = 1,
    parameter int E_HIGH_TICKS    = 1,
    parameter int HOLD_TICKS      = 1,
    parameter int EXEC_TICKS      = 4,
    parameter int EXEC_LONG_TICKS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_tick,
    hd44780_nibble_writer_if.slave     bus,
    output logic                       o_lcd_rs,
    output logic                       o_lcd_rw,
    output logic                       o_lcd_e,
    output logic [3:0]                 o_lcd_db
);
    localparam int M0 = SETUP_TICKS > E_HIGH_TICKS ? SETUP_TICKS : E_HIGH_TICKS;
    localparam int M1 = HOLD_TICKS > EXEC_TICKS ? HOLD_TICKS : EXEC_TICKS;
    localparam int M2 = M0 > M1 ? M0 : M1;
    localparam int MAXP = M2 > EXEC_LONG_TICKS ? M2 : EXEC_LONG_TICKS;
    localparam int CW = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        IDLE, HI_SETUP, HI_EN, HI_HOLD, LO_SETUP, LO_EN, LO_HOLD, EXEC_WAIT
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_byte, w_byte;
    logic          r_rs, w_rs, r_long, r_done;
    logic          r_lcd_rs, r_lcd_e;
    logic [3:0]    r_lcd_db;
    logic          w_accept, w_adv, w_hi, w_lo;
    int            w_lim;

    assign bus.in_ready = r_state == IDLE;
    assign bus.done     = r_done;
    assign o_lcd_rs     = r_lcd_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_e      = r_lcd_e;
    assign o_lcd_db     = r_lcd_db;

    always_comb begin
        w_accept = bus.in_valid && r_state == IDLE;
        w_byte   = w_accept ? bus.in_data : r_byte;
        w_rs     = w_accept ? bus.in_rs : r_rs;
        case (r_state)
            HI_SETUP, LO_SETUP: w_lim = SETUP_TICKS;
            HI_EN, LO_EN:       w_lim = E_HIGH_TICKS;
            HI_HOLD, LO_HOLD:   w_lim = HOLD_TICKS;
            EXEC_WAIT:          w_lim = r_long ? EXEC_LONG_TICKS : EXEC_TICKS;
            default:            w_lim = 1;
        endcase
        w_adv  = r_state != IDLE && i_tick && r_cnt == CW'(w_lim - 1);
        // States are numbered in transfer order, so EXEC_WAIT + 1 wraps to IDLE
        w_next = r_state == IDLE ? (w_accept ? HI_SETUP : IDLE)
               : w_adv ? state_t'(r_state + 3'd1) : r_state;
        w_hi   = w_next == HI_SETUP || w_next == HI_EN || w_next == HI_HOLD;
        w_lo   = w_next == LO_SETUP || w_next == LO_EN || w_next == LO_HOLD;
    end

    // Pins are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_byte   <= '0;
            r_rs     <= 1'b0;
            r_long   <= 1'b0;
            r_done   <= 1'b0;
            r_lcd_rs <= 1'b0;
            r_lcd_e  <= 1'b0;
            r_lcd_db <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_next != r_state ? '0 : r_cnt + CW'(i_tick && r_state != IDLE);
            if (w_accept) begin
                r_byte <= bus.in_data;
                r_rs   <= bus.in_rs;
                r_long <= !bus.in_rs && bus.in_data[7:2] == 6'd0 && bus.in_data[1:0] != 2'd0;
            end
            r_done   <= r_state == EXEC_WAIT && w_adv;
            r_lcd_e  <= w_next == HI_EN || w_next == LO_EN;
            r_lcd_rs <= (w_hi || w_lo) && w_rs;
            r_lcd_db <= w_hi ? w_byte[7:4] : w_lo ? w_byte[3:0] : 4'd0;
        end
    end
endmodule

// File: doc/hd44780_nibble_writer.md
Name: hd44780_nibble_writer

Overview:
- Downstream consumer of the prescaler tick counter: takes one 8-bit command/data byte per valid/ready handshake and drives the HD44780 4-bit bus (RS, RW, E, DB[7:4]) as two nibble transfers.
- Timing is paced solely by the one-cycle `tick` strobe from the prescaler; every phase lasts a parameterised number of ticks.
- Sits between the LCD init/print controller (upstream) and the LCD pins.

Parameters:
- SETUP_TICKS, 1, ticks RS/DB are stable before E rises (min 1)
- E_HIGH_TICKS, 1, ticks E is held high (min 1)
- HOLD_TICKS, 1, ticks RS/DB are held after E falls (min 1)
- EXEC_TICKS, 4, ticks waited after the low nibble for a normal instruction or data write (min 1)
- EXEC_LONG_TICKS, 16, ticks waited after Clear Display (0x01) or Return Home (0x02/0x03) with RS=0 (min 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle timebase strobe from the prescaler counter
- in_valid  in  1  byte request
- in_data  in  8  byte to write
- in_rs  in  1  0 = instruction, 1 = data
- in_ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when a byte completes
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW, constant 0 (write only)
- lcd_e  out  1  LCD enable
- lcd_db  out  4  LCD DB[7:4]

Behaviour:
- **Reset** (async, any state): state = IDLE, tick counter = 0, captured byte/rs = 0. Outputs: in_ready = 1, done = 0, lcd_rs = 0, lcd_rw = 0, lcd_e = 0, lcd_db = 0.
- **Handshake:** a byte is accepted on a rising edge with in_valid && in_ready. On that edge in_data, in_rs and the long-delay decision are registered. The long-delay decision is in_rs == 0 && in_data[7:2] == 0 && in_data[1:0] != 0. in_valid is ignored outside IDLE.
- **States:**
  - IDLE
  - HI_SETUP → HI_EN → HI_HOLD
  - LO_SETUP → LO_EN → LO_HOLD
  - EXEC_WAIT
  - back to IDLE
- **State timing:**
  - Each non-IDLE state has a limit N: SETUP_TICKS, E_HIGH_TICKS, HOLD_TICKS, or EXEC(_LONG)_TICKS.
  - The tick counter clears on every state entry and increments on each cycle with tick = 1.
  - On a cycle with tick = 1 and counter == N-1, the state advances at the next edge.
  - With tick tied high, each state therefore lasts exactly N cycles.
- **Tick qualification:** a tick in IDLE, or coincident with the accepting edge, is ignored; counting starts in HI_SETUP.
- **Outputs by state:**
  - IDLE and EXEC_WAIT: lcd_rs = 0, lcd_e = 0, lcd_db = 0.
  - HI_*: lcd_rs = captured rs, lcd_db = byte[7:4]; lcd_e = 1 only in HI_EN.
  - LO_*: lcd_rs = captured rs, lcd_db = byte[3:0]; lcd_e = 1 only in LO_EN.
- **Glitch-free pins:** all LCD outputs are registered. RS/DB never change in the same cycle E changes.
- **Completion:** the edge leaving EXEC_WAIT enters IDLE with done = 1 for exactly one cycle; in_ready = 1 in that same cycle. A new byte may be accepted on the following edge, giving back-to-back transfers with no extra idle cycle beyond that one.
- **Latency:**
  - Busy duration is SETUP + E_HIGH + HOLD, twice, plus EXEC or EXEC_LONG, in tick-qualified state lengths.
  - With tick = 1 and the defaults: 10 cycles normal, 22 cycles long.
- **Counter width:** $clog2 of the largest parameter, +1. No wrap occurs, because the counter is cleared on every state change.
- **Reset mid-transfer:** the transfer is aborted and E drops immediately; done is not pulsed, and the byte is lost.

Test Plan:
1. **Normal data write.** Stimulus: tick tied 1, defaults, accept 0xA5 with rs = 1. Required response:
   - in_ready low for 10 cycles.
   - lcd_db = 0xA for cycles 1-3, with lcd_e = 1 only in cycle 2.
   - lcd_db = 0x5 for cycles 4-6, with lcd_e = 1 in cycle 5.
   - lcd_rs = 1 for cycles 1-6.
   - done = 1 in cycle 11, with in_ready = 1.
2. **Long-delay detection.** Stimulus: tick = 1, accept 0x01 with rs = 0, then 0x02 with rs = 0. Required response: each takes 22 busy cycles. Accept 0x01 with rs = 1: 10 cycles. Accept 0x04 with rs = 0: 10 cycles.
3. **Slow tick.** Stimulus: tick strobed every 6th cycle, accept 0x38 rs = 0. Required response:
   - lcd_e high exactly 6 cycles per nibble.
   - lcd_db = 0x3, then 0x8.
   - done after 10 tick strobes past HI_SETUP entry.
   - in_valid held high during busy is not re-accepted.
4. **Back-to-back.** Stimulus: in_valid held high with 0x41, then 0x42. Required response: the second byte is accepted on the edge after the done cycle. No lcd_e pulses overlap, and exactly 4 E pulses are seen.
5. **Reset mid-transfer.** Stimulus: assert rst asynchronously during HI_EN. Required response: lcd_e, lcd_db and lcd_rs go to 0 immediately, in_ready = 1, done stays 0. After release, a new byte 0x0C transfers normally.
6. **Parameter sweep.** Stimulus: SETUP = 2, E_HIGH = 3, HOLD = 2, EXEC = 5, tick = 1. Required response: E high 3 cycles per nibble, 2-cycle setup/hold verified around each E edge, total busy = 19 cycles.
